// File: rtl/matrix_op_defs_pkg.sv
// Shared constants, writer state encoding and metadata packing for the matrix storage units.
package matrix_op_defs_pkg;

  localparam int MATRIX_DATA_WIDTH     = 32;
  localparam int MATRIX_ADDR_WIDTH     = 12;
  localparam int MATRIX_BLOCK_SIZE     = 256;
  localparam int MATRIX_METADATA_WORDS = 3;

  typedef enum logic [2:0] {
    WR_IDLE,
    WR_META0,
    WR_META1,
    WR_META2,
    WR_STREAM,
    WR_DONE
  } matrix_writer_state_e;

  function automatic logic [31:0] pack_meta_word(input logic [7:0] rows, input logic [7:0] cols);
    return {rows, cols, 16'h0000};
  endfunction

endpackage

// File: rtl/matrix_block_writer.sv
// Commits one matrix (3 metadata words + row-major data) into its ID's BRAM block
// and tracks which IDs hold a complete matrix.
//   state     | meaning
//   WR_IDLE   | ready for a request; validates and latches it
//   WR_META0  | write {rows, cols, 0} at base+0
//   WR_META1  | write name bytes 0..3 at base+1
//   WR_META2  | write name bytes 4..7 at base+2
//   WR_STREAM | write one data word per data_valid beat
//   WR_DONE   | completion pulse, publish valid bit on success
module matrix_block_writer
  import matrix_op_defs_pkg::*;
#(
  parameter int DATA_WIDTH   = MATRIX_DATA_WIDTH,
  parameter int ADDR_WIDTH   = MATRIX_ADDR_WIDTH,
  parameter int BLOCK_SIZE   = MATRIX_BLOCK_SIZE,
  parameter int MATRIX_COUNT = 8
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    write_request,
  output logic                    write_ready,
  input  logic [2:0]              matrix_id,
  input  logic [7:0]              actual_rows,
  input  logic [7:0]              actual_cols,
  input  logic [0:7][7:0]         matrix_name,
  input  logic [DATA_WIDTH-1:0]   data_in,
  input  logic                    data_valid,
  output logic                    writer_ready,
  output logic                    write_done,
  output logic                    write_error,
  output logic                    bram_we,
  output logic [ADDR_WIDTH-1:0]   bram_addr,
  output logic [DATA_WIDTH-1:0]   bram_wdata,
  output logic [MATRIX_COUNT-1:0] matrix_valid
);

  matrix_writer_state_e state, state_next;

  logic [2:0]              id_q;
  logic [7:0]              rows_q, cols_q;
  logic [0:7][7:0]         name_q;
  logic [15:0]             words_q, idx_q;
  logic [31:0]             base_q;
  logic                    error_q;
  logic [MATRIX_COUNT-1:0] valid_q;

  logic [15:0] req_words;
  logic [31:0] req_base;
  logic        req_bad;
  logic        beat;

  assign req_words = 16'(actual_rows) * 16'(actual_cols);
  assign req_base  = 32'(matrix_id) * 32'(BLOCK_SIZE);
  // Compare in 32 bits so the metadata overhead cannot wrap the 16-bit word count.
  assign req_bad   = (actual_rows == 8'd0) || (actual_cols == 8'd0) ||
                     ((32'(req_words) + 32'(MATRIX_METADATA_WORDS)) > 32'(BLOCK_SIZE));
  assign beat      = (state == WR_STREAM) && data_valid;

  assign matrix_valid = valid_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= WR_IDLE;
      id_q    <= '0;
      rows_q  <= '0;
      cols_q  <= '0;
      name_q  <= '0;
      words_q <= '0;
      idx_q   <= '0;
      base_q  <= '0;
      error_q <= 1'b0;
      valid_q <= '0;
    end else begin
      state <= state_next;
      case (state)
        WR_IDLE: begin
          if (write_request) begin
            id_q    <= matrix_id;
            rows_q  <= actual_rows;
            cols_q  <= actual_cols;
            name_q  <= matrix_name;
            words_q <= req_words;
            base_q  <= req_base;
            idx_q   <= '0;
            error_q <= req_bad;
            if (!req_bad) valid_q[matrix_id] <= 1'b0;
          end
        end
        WR_STREAM: if (beat) idx_q <= idx_q + 16'd1;
        WR_DONE:   if (!error_q) valid_q[id_q] <= 1'b1;
        default: ;
      endcase
    end
  end

  always_comb begin
    state_next   = state;
    write_ready  = 1'b0;
    writer_ready = 1'b0;
    write_done   = 1'b0;
    write_error  = 1'b0;
    bram_we      = 1'b0;
    bram_addr    = '0;
    bram_wdata   = '0;
    case (state)
      WR_IDLE: begin
        write_ready = 1'b1;
        if (write_request) state_next = req_bad ? WR_DONE : WR_META0;
      end
      WR_META0: begin
        bram_we    = 1'b1;
        bram_addr  = ADDR_WIDTH'(base_q);
        bram_wdata = DATA_WIDTH'(pack_meta_word(rows_q, cols_q));
        state_next = WR_META1;
      end
      WR_META1: begin
        bram_we    = 1'b1;
        bram_addr  = ADDR_WIDTH'(base_q + 32'd1);
        bram_wdata = DATA_WIDTH'({name_q[0], name_q[1], name_q[2], name_q[3]});
        state_next = WR_META2;
      end
      WR_META2: begin
        bram_we    = 1'b1;
        bram_addr  = ADDR_WIDTH'(base_q + 32'd2);
        bram_wdata = DATA_WIDTH'({name_q[4], name_q[5], name_q[6], name_q[7]});
        state_next = WR_STREAM;
      end
      WR_STREAM: begin
        writer_ready = 1'b1;
        if (beat) begin
          bram_we    = 1'b1;
          bram_addr  = ADDR_WIDTH'(base_q + 32'(MATRIX_METADATA_WORDS) + 32'(idx_q));
          bram_wdata = data_in;
          if (idx_q == words_q - 16'd1) state_next = WR_DONE;
        end
      end
      WR_DONE: begin
        write_done  = 1'b1;
        write_error = error_q;
        state_next  = WR_IDLE;
      end
      default: state_next = WR_IDLE;
    endcase
  end

endmodule
